// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    localparam int          BLOCK_WORDS = 16;
    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          LEN_HI_IDX  = 14;
    localparam int          LEN_LO_IDX  = 15;

    typedef logic [31:0] word_t;
    typedef word_t [0:BLOCK_WORDS-1] block_t;

    typedef enum logic [1:0] {NONE, PADLEN, LENONLY} tail_e;
    typedef enum logic       {FILL, EMIT}            state_e;

    // Overflow block holding only the length, optionally preceded by the 0x80 marker.
    function automatic block_t tail_block(input logic with_pad, input logic [63:0] len);
        block_t b;
        b = '0;
        if (with_pad) b[0] = PAD_WORD;
        b[LEN_HI_IDX] = len[63:32];
        b[LEN_LO_IDX] = len[31:0];
        return b;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaper: keeps the first n bytes, writes 0x80 at byte n, zeroes the rest.
// Purely combinational; no flow control.
// n values above 4 are clamped to 4 (full word, marker goes into the next word).
module sha256_pad_word
    import sha256_pkg::*;
(
    input  word_t      in_data,
    input  logic [2:0] in_bytes,
    output word_t      pad_dat,
    output logic [2:0] nbytes,
    output logic       full
);

    always_comb begin
        nbytes  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        full    = (nbytes == 3'd4);
        pad_dat = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes) begin
                pad_dat[31-8*k -: 8] = in_data[31-8*k -: 8];
            end else if (3'(k) == nbytes) begin
                pad_dat[31-8*k -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: buffers 32-bit words into 512-bit blocks and applies length padding.
// Latency: a block is presented the cycle after its completing word is accepted.
// Backpressure: input stalls (in_ready=0) for as long as a block waits on blk_ready. Optional blk_cnt via SHA256_PAD_BLKCNT_EN.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  word_t       in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        blk_valid,
    input  logic        blk_ready,
    output block_t      blk_data,
    output logic        blk_first,
    output logic        blk_last
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    state_e             state_q, state_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   bitlen_q, bitlen_d;
    tail_e              tail_q, tail_d;
    logic               first_pend_q, first_pend_d;
    logic               blk_first_q, blk_first_d;
    logic               blk_last_q, blk_last_d;
    block_t             buf_q, buf_d;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0]        blk_cnt_q, blk_cnt_d;
`endif

    word_t              pad_dat;
    logic [2:0]         nbytes;
    logic               pad_full;
    logic               accept;
    logic [LEN_W-1:0]   fin_len;
    logic [63:0]        fin_len64;
    logic [63:0]        tail_len64;
    logic [4:0]         free_idx;

    sha256_pad_word u_pad_word (
        .in_data  (in_data),
        .in_bytes (in_bytes),
        .pad_dat  (pad_dat),
        .nbytes   (nbytes),
        .full     (pad_full)
    );

    assign in_ready  = (state_q == FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign blk_valid = (state_q == EMIT);
    assign blk_data  = buf_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
`ifdef SHA256_PAD_BLKCNT_EN
    assign blk_cnt   = blk_cnt_q;
`endif

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        bitlen_d     = bitlen_q;
        tail_d       = tail_q;
        first_pend_d = first_pend_q;
        blk_first_d  = blk_first_q;
        blk_last_d   = blk_last_q;
        buf_d        = buf_q;
`ifdef SHA256_PAD_BLKCNT_EN
        blk_cnt_d    = blk_cnt_q;
`endif
        fin_len    = bitlen_q + LEN_W'({nbytes, 3'b000});
        fin_len64  = 64'(fin_len);
        tail_len64 = 64'(bitlen_q);
        // First word index left free after the message bytes and the 0x80 marker.
        free_idx   = {1'b0, widx_q} + (pad_full ? 5'd2 : 5'd1);

        case (state_q)
            FILL: begin
                if (accept && !in_last) begin
                    buf_d[widx_q] = in_data;
                    bitlen_d      = bitlen_q + LEN_W'(32);
                    if (widx_q == 4'd15) begin
                        state_d     = EMIT;
                        widx_d      = '0;
                        blk_first_d = first_pend_q;
                        blk_last_d  = 1'b0;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end else if (accept) begin
                    bitlen_d = fin_len;
                    for (int i = 0; i < BLOCK_WORDS; i++) begin
                        if (5'(i) < {1'b0, widx_q}) begin
                            buf_d[i] = buf_q[i];
                        end else if (5'(i) == {1'b0, widx_q}) begin
                            buf_d[i] = pad_dat;
                        end else if (pad_full && (5'(i) == {1'b0, widx_q} + 5'd1)) begin
                            buf_d[i] = PAD_WORD;
                        end else begin
                            buf_d[i] = '0;
                        end
                    end
                    if (free_idx <= 5'd14) begin
                        buf_d[LEN_HI_IDX] = fin_len64[63:32];
                        buf_d[LEN_LO_IDX] = fin_len64[31:0];
                        blk_last_d        = 1'b1;
                    end else if (free_idx <= 5'd16) begin
                        blk_last_d = 1'b0;
                        tail_d     = LENONLY;
                    end else begin
                        blk_last_d = 1'b0;
                        tail_d     = PADLEN;
                    end
                    state_d     = EMIT;
                    widx_d      = '0;
                    blk_first_d = first_pend_q;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    if (tail_q != NONE) begin
                        buf_d       = tail_block(tail_q == PADLEN, tail_len64);
                        blk_first_d = 1'b0;
                        blk_last_d  = 1'b1;
                        tail_d      = NONE;
`ifdef SHA256_PAD_BLKCNT_EN
                        blk_cnt_d   = blk_cnt_q + 16'd1;
`endif
                    end else if (blk_last_q) begin
                        state_d      = FILL;
                        bitlen_d     = '0;
                        first_pend_d = 1'b1;
`ifdef SHA256_PAD_BLKCNT_EN
                        blk_cnt_d    = '0;
`endif
                    end else begin
                        state_d      = FILL;
                        first_pend_d = 1'b0;
`ifdef SHA256_PAD_BLKCNT_EN
                        blk_cnt_d    = blk_cnt_q + 16'd1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            widx_q       <= '0;
            bitlen_q     <= '0;
            tail_q       <= NONE;
            first_pend_q <= 1'b1;
            blk_first_q  <= 1'b0;
            blk_last_q   <= 1'b0;
            buf_q        <= '0;
`ifdef SHA256_PAD_BLKCNT_EN
            blk_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            bitlen_q     <= bitlen_d;
            tail_q       <= tail_d;
            first_pend_q <= first_pend_d;
            blk_first_q  <= blk_first_d;
            blk_last_q   <= blk_last_d;
            buf_q        <= buf_d;
`ifdef SHA256_PAD_BLKCNT_EN
            blk_cnt_q    <= blk_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed table, stall/reset sequences and random messages
// checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    word_t       in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        blk_valid;
    logic        blk_ready;
    block_t      blk_data;
    logic        blk_first;
    logic        blk_last;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        block_t      d;
        logic        f;
        logic        l;
        logic [15:0] cnt;
    } rec_t;

    typedef struct {
        int         nfull;
        word_t      lastw;
        logic [2:0] nb;
        int         nblk;
        word_t      a14;
        word_t      f0;
        word_t      f15;
    } vec_t;

    rec_t exp_q[$];
    rec_t rx_q[$];
    rec_t got_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic chk_blk(input string nm, input block_t got, input block_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    function automatic word_t pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Reference: FIPS 180-4 padding on a plain byte list, then cut into 64-byte blocks.
    task automatic model_msg(input word_t w[$], input logic [2:0] nb);
        logic [7:0]  by[$];
        logic [63:0] bits;
        int          nl;
        int          nblk;
        nl = (nb > 3'd4) ? 4 : int'(nb);
        for (int i = 0; i < w.size(); i++) begin
            int k;
            k = (i == w.size() - 1) ? nl : 4;
            for (int j = 0; j < k; j++) by.push_back(w[i][31-8*j -: 8]);
        end
        bits = 64'(by.size()) * 64'd8;
        by.push_back(8'h80);
        while (by.size() % 64 != 56) by.push_back(8'h00);
        for (int j = 7; j >= 0; j--) by.push_back(bits[8*j +: 8]);
        nblk = by.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            rec_t r;
            for (int i = 0; i < 16; i++)
                r.d[i] = {by[b*64+4*i], by[b*64+4*i+1], by[b*64+4*i+2], by[b*64+4*i+3]};
            r.f   = (b == 0);
            r.l   = (b == nblk - 1);
            r.cnt = 16'(b);
            exp_q.push_back(r);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic drive_word(input word_t d, input logic l, input logic [2:0] b);
        int cyc;
        cyc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input word_t w[$], input logic [2:0] nb, input int gap);
        model_msg(w, nb);
        for (int i = 0; i < w.size(); i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            if (i == w.size() - 1) drive_word(w[i], 1'b1, nb);
            else                   drive_word(w[i], 1'b0, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic check_rx(input string tag);
        int cyc;
        cyc = 0;
        while (rx_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_nblk"}, 64'(rx_q.size()), 64'(exp_q.size()));
        got_q = rx_q;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            rec_t e;
            rec_t g;
            e = exp_q.pop_front();
            g = rx_q.pop_front();
            chk_blk({tag, "_data"}, g.d, e.d);
            chk({tag, "_flags"}, 64'({g.f, g.l}), 64'({e.f, e.l}));
`ifdef SHA256_PAD_BLKCNT_EN
            chk({tag, "_cnt"}, 64'(g.cnt), 64'(e.cnt));
`endif
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    // Consumer: randomly ready; a block is recorded when it will be taken at the next posedge.
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                blk_ready = ($urandom_range(0, 3) != 0);
                if (blk_valid && blk_ready && !reset) begin
                    rec_t r;
                    r.d   = blk_data;
                    r.f   = blk_first;
                    r.l   = blk_last;
`ifdef SHA256_PAD_BLKCNT_EN
                    r.cnt = blk_cnt;
`else
                    r.cnt = 16'd0;
`endif
                    rx_q.push_back(r);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t   vt[9];
        word_t  msg[$];
        block_t abc_blk;
        int     cyc;

        vt[0] = '{0,  32'h6162_6300, 3'd3, 1, 32'h0,         32'h6162_6380, 32'h18};
        vt[1] = '{0,  32'h0000_0000, 3'd0, 1, 32'h0,         32'h8000_0000, 32'h0};
        vt[2] = '{13, 32'h1357_9BDF, 3'd4, 2, 32'h8000_0000, 32'h0,         32'h1C0};
        vt[3] = '{15, 32'h2468_ACE0, 3'd4, 2, 32'hA500_000E, 32'h8000_0000, 32'h200};
        vt[4] = '{0,  32'hDEAD_BEEF, 3'd7, 1, 32'h0,         32'hDEAD_BEEF, 32'h20};
        vt[5] = '{2,  32'h1122_3344, 3'd1, 1, 32'h0,         32'hA500_0000, 32'h48};
        vt[6] = '{14, 32'hAABB_CCDD, 3'd2, 2, 32'hAABB_8000, 32'h0,         32'h1D0};
        vt[7] = '{15, 32'h1234_5678, 3'd0, 2, 32'hA500_000E, 32'h0,         32'h1E0};
        vt[8] = '{39, 32'hCAFE_F00D, 3'd4, 3, 32'hA500_000E, 32'hA500_0020, 32'h500};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold_ready_valid", 64'({in_ready, blk_valid}), 64'(2'b00));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", 64'({in_ready, blk_valid, blk_first, blk_last}), 64'(4'b1000));
        chk_blk("rst_data", blk_data, '0);

        for (int t = 0; t < 9; t++) begin
            msg.delete();
            for (int i = 0; i < vt[t].nfull; i++) msg.push_back(pat(i));
            msg.push_back(vt[t].lastw);
            send_msg(msg, vt[t].nb, 1);
            check_rx($sformatf("vec%0d", t));
            chk($sformatf("vec%0d_tbl_nblk", t), 64'(got_q.size()), 64'(vt[t].nblk));
            if (got_q.size() > 0) begin
                chk($sformatf("vec%0d_w14_first", t), 64'(got_q[0].d[14]), 64'(vt[t].a14));
                chk($sformatf("vec%0d_w0_final", t), 64'(got_q[got_q.size()-1].d[0]), 64'(vt[t].f0));
                chk($sformatf("vec%0d_w15_final", t), 64'(got_q[got_q.size()-1].d[15]), 64'(vt[t].f15));
            end
        end

        // Consumer stall: block and flags must hold, input must stay blocked.
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        blk_ready = 1'b0;
        @(negedge clk);
        msg.delete();
        msg.push_back(32'h6162_6300);
        model_msg(msg, 3'd3);
        abc_blk = exp_q[0].d;
        exp_q.delete();
        drive_word(32'h6162_6300, 1'b1, 3'd3);
        cyc = 0;
        while (!blk_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int c = 0; c < 10; c++) begin
            chk("stall_hold", 64'({blk_valid, in_ready, blk_first, blk_last, blk_data === abc_blk}),
                64'(5'b10111));
            @(negedge clk);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("stall_release", 64'({blk_valid, in_ready}), 64'(2'b01));

        // Reset while a full block is waiting, then reset in the middle of a message.
        for (int i = 0; i < 16; i++) drive_word(pat(i), 1'b0, 3'd0);
        chk("emit_before_rst", 64'(blk_valid), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_emit", 64'({blk_valid, in_ready}), 64'(2'b00));
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 64'({blk_valid, in_ready}), 64'(2'b01));
        for (int i = 0; i < 3; i++) drive_word(pat(100 + i), 1'b0, 3'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        msg.delete();
        msg.push_back(32'h6162_6300);
        send_msg(msg, 3'd3, 0);
        check_rx("post_rst");

        for (int m = 0; m < 25; m++) begin
            int nw;
            nw = $urandom_range(1, 40);
            msg.delete();
            for (int i = 0; i < nw; i++) msg.push_back($urandom);
            send_msg(msg, 3'($urandom_range(0, 7)), 2);
            check_rx($sformatf("rand%0d", m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
